// File: rtl/row_pe_minsum_gen_if.sv
// Row PE streaming bundle: one row of v2c messages in, one row of c2v messages out,
// each side with its own valid/ready handshake. Driver side = master, PE side = slave.
interface row_pe_minsum_gen_if #(
   parameter int QUAN_SIZE = 4,
   parameter int CN_DEGREE = 10,
   parameter int FRAME_BW  = 1
);
   logic [CN_DEGREE*QUAN_SIZE-1:0] v2c_in;
   logic [CN_DEGREE*QUAN_SIZE-1:0] ch_msg_in;
   logic                           v2c_src;
   logic [FRAME_BW-1:0]            in_frame_id;
   logic                           in_valid;
   logic                           in_ready;
   logic [CN_DEGREE*QUAN_SIZE-1:0] c2v_out;
   logic                           parity_out;
   logic [FRAME_BW-1:0]            out_frame_id;
   logic                           out_valid;
   logic                           out_ready;

   modport master (
      output v2c_in, ch_msg_in, v2c_src, in_frame_id, in_valid, out_ready,
      input  in_ready, c2v_out, parity_out, out_frame_id, out_valid
   );

   modport slave (
      input  v2c_in, ch_msg_in, v2c_src, in_frame_id, in_valid, out_ready,
      output in_ready, c2v_out, parity_out, out_frame_id, out_valid
   );
endinterface

// File: rtl/row_pe_minsum_gen.sv
// Offset min-sum check-node row PE, 3-stage valid/ready pipeline with frame tag and parity.
// Optional unsatisfied-check counter is compiled in when ROW_PE_UNSAT_CNT_EN is defined.
module row_pe_minsum_gen #(
   parameter int QUAN_SIZE       = 4,
   parameter int CN_DEGREE       = 10,
   parameter int OFFSET          = 0,
   parameter int MULTI_FRAME_NUM = 2
) (
   input  logic                 read_clk,
   input  logic                 rstn,
   row_pe_minsum_gen_if.slave   bus
`ifdef ROW_PE_UNSAT_CNT_EN
   ,
   output logic [15:0]          unsat_cnt,
   input  logic                 unsat_clr
`endif
);
   localparam int FRAME_BW = (MULTI_FRAME_NUM > 1) ? $clog2(MULTI_FRAME_NUM) : 1;
   localparam int MAG_W    = QUAN_SIZE - 1;
   localparam int IDX_BW   = $clog2(CN_DEGREE);
   localparam int W        = CN_DEGREE * QUAN_SIZE;
   localparam logic [MAG_W-1:0] OFF_M   = MAG_W'(OFFSET);
   localparam logic [MAG_W-1:0] MAG_MAX = '1;

   // Stage 1: muxed input row
   logic                 s1_valid_q;
   logic [W-1:0]         s1_msg_q, s1_msg_d;
   logic [FRAME_BW-1:0]  s1_frame_q;

   // Stage 2: min-sum reduction results
   logic                 s2_valid_q;
   logic                 s2_sgn_q, s2_sgn_d;
   logic [CN_DEGREE-1:0] s2_sign_q, s2_sign_d;
   logic [MAG_W-1:0]     s2_min1_q, s2_min1_d;
   logic [MAG_W-1:0]     s2_min2_q, s2_min2_d;
   logic [IDX_BW-1:0]    s2_idx1_q, s2_idx1_d;
   logic [FRAME_BW-1:0]  s2_frame_q;

   // Stage 3: output lanes
   logic                 out_valid_q;
   logic [W-1:0]         c2v_q, c2v_d;
   logic                 parity_q;
   logic [FRAME_BW-1:0]  out_frame_q;

   logic                 adv;
   logic [MAG_W-1:0]     s1_mag [CN_DEGREE];

   // A stalled output freezes the whole pipeline; bubbles are squeezed only at the output.
   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv && rstn;

   assign s1_msg_d = bus.v2c_src ? bus.ch_msg_in : bus.v2c_in;

   genvar gi;
   generate
      for (gi = 0; gi < CN_DEGREE; gi++) begin : g_split
         assign s1_mag[gi]    = s1_msg_q[gi*QUAN_SIZE +: MAG_W];
         assign s2_sign_d[gi] = s1_msg_q[gi*QUAN_SIZE + QUAN_SIZE - 1];
      end
   endgenerate

   assign s2_sgn_d = ^s2_sign_d;

   // Strict less-than keeps idx1 on the lowest lane and lets a duplicate land in min2.
   always_comb begin
      s2_min1_d = MAG_MAX;
      s2_min2_d = MAG_MAX;
      s2_idx1_d = '0;
      for (int i = 0; i < CN_DEGREE; i++) begin
         if (s1_mag[i] < s2_min1_d) begin
            s2_min2_d = s2_min1_d;
            s2_min1_d = s1_mag[i];
            s2_idx1_d = IDX_BW'(i);
         end else if (s1_mag[i] < s2_min2_d) begin
            s2_min2_d = s1_mag[i];
         end
      end
   end

   generate
      for (gi = 0; gi < CN_DEGREE; gi++) begin : g_lane
         localparam logic [IDX_BW-1:0] LANE = IDX_BW'(gi);
         logic [MAG_W-1:0] m_sel;
         logic [MAG_W-1:0] m_off;
         assign m_sel = (s2_idx1_q == LANE) ? s2_min2_q : s2_min1_q;
         assign m_off = (m_sel > OFF_M) ? (m_sel - OFF_M) : '0;
         // Zero magnitude is always emitted as positive zero.
         assign c2v_d[gi*QUAN_SIZE +: QUAN_SIZE] =
            (m_off == '0) ? '0 : {s2_sgn_q ^ s2_sign_q[gi], m_off};
      end
   endgenerate

   always_ff @(posedge read_clk) begin
      if (!rstn) begin
         s1_valid_q  <= 1'b0;
         s1_msg_q    <= '0;
         s1_frame_q  <= '0;
         s2_valid_q  <= 1'b0;
         s2_sgn_q    <= 1'b0;
         s2_sign_q   <= '0;
         s2_min1_q   <= '0;
         s2_min2_q   <= '0;
         s2_idx1_q   <= '0;
         s2_frame_q  <= '0;
         out_valid_q <= 1'b0;
         c2v_q       <= '0;
         parity_q    <= 1'b0;
         out_frame_q <= '0;
      end else if (adv) begin
         s1_valid_q  <= bus.in_valid;
         s1_msg_q    <= s1_msg_d;
         s1_frame_q  <= bus.in_frame_id;
         s2_valid_q  <= s1_valid_q;
         s2_sgn_q    <= s2_sgn_d;
         s2_sign_q   <= s2_sign_d;
         s2_min1_q   <= s2_min1_d;
         s2_min2_q   <= s2_min2_d;
         s2_idx1_q   <= s2_idx1_d;
         s2_frame_q  <= s1_frame_q;
         out_valid_q <= s2_valid_q;
         c2v_q       <= c2v_d;
         parity_q    <= s2_sgn_q;
         out_frame_q <= s2_frame_q;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.c2v_out      = c2v_q;
   assign bus.parity_out   = parity_q;
   assign bus.out_frame_id = out_frame_q;

`ifdef ROW_PE_UNSAT_CNT_EN
   logic [15:0] unsat_q, unsat_d;

   always_comb begin
      unsat_d = unsat_q;
      if (unsat_clr) begin
         unsat_d = '0;
      end else if (out_valid_q && bus.out_ready && parity_q && (unsat_q != 16'hFFFF)) begin
         unsat_d = unsat_q + 16'd1;
      end
   end

   always_ff @(posedge read_clk) begin
      if (!rstn) begin
         unsat_q <= '0;
      end else begin
         unsat_q <= unsat_d;
      end
   end

   assign unsat_cnt = unsat_q;
`endif
endmodule

// File: tb/tb_row_pe_minsum_gen.sv
// Directed bench for row_pe_minsum_gen: two instances (OFFSET 0 and 1) share one stimulus stream.
module tb_row_pe_minsum_gen;
   localparam int QS = 4;
   localparam int CD = 10;
   localparam int W  = QS * CD;

   logic         clk = 1'b0;
   logic         rstn;
   logic [W-1:0] v2c_in;
   logic [W-1:0] ch_msg_in;
   logic         v2c_src;
   logic         fid;
   logic         in_valid;
   logic         out_ready;
   int           n_cmp = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   row_pe_minsum_gen_if #(.QUAN_SIZE(QS), .CN_DEGREE(CD), .FRAME_BW(1)) bif0 ();
   row_pe_minsum_gen_if #(.QUAN_SIZE(QS), .CN_DEGREE(CD), .FRAME_BW(1)) bif1 ();

   assign bif0.v2c_in      = v2c_in;
   assign bif0.ch_msg_in   = ch_msg_in;
   assign bif0.v2c_src     = v2c_src;
   assign bif0.in_frame_id = fid;
   assign bif0.in_valid    = in_valid;
   assign bif0.out_ready   = out_ready;
   assign bif1.v2c_in      = v2c_in;
   assign bif1.ch_msg_in   = ch_msg_in;
   assign bif1.v2c_src     = v2c_src;
   assign bif1.in_frame_id = fid;
   assign bif1.in_valid    = in_valid;
   assign bif1.out_ready   = out_ready;

`ifdef ROW_PE_UNSAT_CNT_EN
   logic        unsat_clr;
   logic [15:0] unsat_cnt0;
   logic [15:0] unsat_cnt1;

   row_pe_minsum_gen #(.QUAN_SIZE(QS), .CN_DEGREE(CD), .OFFSET(0), .MULTI_FRAME_NUM(2)) dut0 (
      .read_clk(clk), .rstn(rstn), .bus(bif0), .unsat_cnt(unsat_cnt0), .unsat_clr(unsat_clr));
   row_pe_minsum_gen #(.QUAN_SIZE(QS), .CN_DEGREE(CD), .OFFSET(1), .MULTI_FRAME_NUM(2)) dut1 (
      .read_clk(clk), .rstn(rstn), .bus(bif1), .unsat_cnt(unsat_cnt1), .unsat_clr(unsat_clr));
`else
   row_pe_minsum_gen #(.QUAN_SIZE(QS), .CN_DEGREE(CD), .OFFSET(0), .MULTI_FRAME_NUM(2)) dut0 (
      .read_clk(clk), .rstn(rstn), .bus(bif0));
   row_pe_minsum_gen #(.QUAN_SIZE(QS), .CN_DEGREE(CD), .OFFSET(1), .MULTI_FRAME_NUM(2)) dut1 (
      .read_clk(clk), .rstn(rstn), .bus(bif1));
`endif

   function automatic logic [W-1:0] all_lanes(input logic [QS-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < CD; i++) r[i*QS +: QS] = v;
      return r;
   endfunction

   function automatic logic [W-1:0] put_lane(input logic [W-1:0] vec, input int idx,
                                             input logic [QS-1:0] v);
      logic [W-1:0] r;
      r = vec;
      r[idx*QS +: QS] = v;
      return r;
   endfunction

   task automatic idle_inputs;
      in_valid  = 1'b0;
      v2c_src   = 1'b0;
      v2c_in    = '0;
      ch_msg_in = '0;
      fid       = 1'b0;
   endtask

   // Presents one row for one cycle and stops at the negedge where it should be on the output.
   task automatic issue_row(input logic src, input logic [W-1:0] v, input logic [W-1:0] ch,
                            input logic f, output logic early);
      v2c_src   = src;
      v2c_in    = v;
      ch_msg_in = ch;
      fid       = f;
      in_valid  = 1'b1;
      early     = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      early    = early | bif0.out_valid;
      @(negedge clk);
      early    = early | bif0.out_valid;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rstn      = 1'b0;
      out_ready = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      n_cmp++; if (bif0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bif0.out_valid); end
      n_cmp++; if (bif0.c2v_out !== '0) begin n_err++; $display("FAIL rst_c2v: got %h expected 0", bif0.c2v_out); end
      n_cmp++; if (bif0.parity_out !== 1'b0) begin n_err++; $display("FAIL rst_parity: got %b expected 0", bif0.parity_out); end
      n_cmp++; if (bif0.out_frame_id !== 1'b0) begin n_err++; $display("FAIL rst_frame: got %b expected 0", bif0.out_frame_id); end
      n_cmp++; if (bif0.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", bif0.in_ready); end
      rstn = 1'b1;
      @(negedge clk);
      n_cmp++; if (bif0.in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b expected 1", bif0.in_ready); end
      $display("test_reset done");
   endtask

   task automatic test_basic;
      logic early;
      logic [W-1:0] stim, exp0;
      stim = put_lane(all_lanes(4'b0011), 2, 4'b1001);
      exp0 = put_lane(all_lanes(4'b1001), 2, 4'b0011);
      issue_row(1'b0, stim, all_lanes(4'b0111), 1'b0, early);
      n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL basic_latency_early: got %b expected 0", early); end
      n_cmp++; if (bif0.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", bif0.out_valid); end
      n_cmp++; if (bif0.c2v_out !== exp0) begin n_err++; $display("FAIL basic_c2v: got %h expected %h", bif0.c2v_out, exp0); end
      n_cmp++; if (bif0.parity_out !== 1'b1) begin n_err++; $display("FAIL basic_parity: got %b expected 1", bif0.parity_out); end
      n_cmp++; if (bif0.out_frame_id !== 1'b0) begin n_err++; $display("FAIL basic_frame: got %b expected 0", bif0.out_frame_id); end
      @(negedge clk);
      n_cmp++; if (bif0.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_single: got %b expected 0", bif0.out_valid); end
      $display("test_basic: c2v=%h parity=%b", exp0, 1'b1);
   endtask

   task automatic test_offset;
      logic early;
      logic [W-1:0] stim, exp1;
      stim = put_lane(all_lanes(4'b0011), 2, 4'b1001);
      exp1 = put_lane(all_lanes(4'b0000), 2, 4'b0010);
      issue_row(1'b0, stim, '0, 1'b0, early);
      n_cmp++; if (bif1.out_valid !== 1'b1) begin n_err++; $display("FAIL offset_valid: got %b expected 1", bif1.out_valid); end
      n_cmp++; if (bif1.c2v_out !== exp1) begin n_err++; $display("FAIL offset_c2v: got %h expected %h", bif1.c2v_out, exp1); end
      n_cmp++; if (bif1.parity_out !== 1'b1) begin n_err++; $display("FAIL offset_parity: got %b expected 1", bif1.parity_out); end
      @(negedge clk);
      $display("test_offset: c2v=%h", exp1);
   endtask

   task automatic test_tie_src;
      logic early;
      logic [W-1:0] ch, exp0;
      ch   = put_lane(put_lane(all_lanes(4'b0111), 0, 4'b0001), 5, 4'b0001);
      exp0 = all_lanes(4'b0001);
      issue_row(1'b1, all_lanes(4'b1010), ch, 1'b1, early);
      n_cmp++; if (bif0.out_valid !== 1'b1) begin n_err++; $display("FAIL tie_valid: got %b expected 1", bif0.out_valid); end
      n_cmp++; if (bif0.c2v_out !== exp0) begin n_err++; $display("FAIL tie_c2v: got %h expected %h", bif0.c2v_out, exp0); end
      n_cmp++; if (bif0.parity_out !== 1'b0) begin n_err++; $display("FAIL tie_parity: got %b expected 0", bif0.parity_out); end
      n_cmp++; if (bif0.out_frame_id !== 1'b1) begin n_err++; $display("FAIL tie_frame: got %b expected 1", bif0.out_frame_id); end
      n_cmp++; if (bif1.c2v_out !== '0) begin n_err++; $display("FAIL tie_offset_c2v: got %h expected 0", bif1.c2v_out); end
      @(negedge clk);
      $display("test_tie_src: c2v=%h", exp0);
   endtask

   task automatic test_negzero;
      logic early;
      logic [W-1:0] stim, exp0, exp1;
      stim = put_lane(all_lanes(4'b0101), 7, 4'b1000);
      exp0 = put_lane(all_lanes(4'b0000), 7, 4'b0101);
      exp1 = put_lane(all_lanes(4'b0000), 7, 4'b0100);
      issue_row(1'b0, stim, '0, 1'b0, early);
      n_cmp++; if (bif0.c2v_out !== exp0) begin n_err++; $display("FAIL negzero_c2v: got %h expected %h", bif0.c2v_out, exp0); end
      n_cmp++; if (bif0.parity_out !== 1'b1) begin n_err++; $display("FAIL negzero_parity: got %b expected 1", bif0.parity_out); end
      n_cmp++; if (bif1.c2v_out !== exp1) begin n_err++; $display("FAIL negzero_offset_c2v: got %h expected %h", bif1.c2v_out, exp1); end
      @(negedge clk);
      $display("test_negzero: c2v=%h", exp0);
   endtask

   task automatic test_back_to_back;
      int           sent = 0;
      int           recv = 0;
      int           stall_left = 0;
      logic         stall_done = 1'b0;
      logic         prev_stall = 1'b0;
      logic [W-1:0] prev_c2v = '0;
      logic         prev_f = 1'b0;
      logic [W-1:0] exp;
      out_ready = 1'b1;
      idle_inputs();
      for (int cyc = 0; cyc < 60 && recv < 5; cyc++) begin
         if (bif0.out_valid && !stall_done) begin
            stall_left = 4;
            stall_done = 1'b1;
         end
         out_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         #1;
         if (prev_stall) begin
            n_cmp++;
            if (bif0.out_valid !== 1'b1 || bif0.c2v_out !== prev_c2v || bif0.out_frame_id !== prev_f) begin
               n_err++;
               $display("FAIL bp_hold: got v=%b c2v=%h f=%b expected v=1 c2v=%h f=%b",
                        bif0.out_valid, bif0.c2v_out, bif0.out_frame_id, prev_c2v, prev_f);
            end
         end
         n_cmp++;
         if (bif0.out_valid && !out_ready) begin
            if (bif0.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_stall: got %b expected 0", bif0.in_ready); end
         end else begin
            if (bif0.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_run: got %b expected 1", bif0.in_ready); end
         end
         if (bif0.out_valid && out_ready) begin
            exp = put_lane(all_lanes(4'b0001), recv, 4'b0111);
            n_cmp++;
            if (bif0.c2v_out !== exp || bif0.out_frame_id !== recv[0]) begin
               n_err++;
               $display("FAIL bp_row%0d: got c2v=%h f=%b expected c2v=%h f=%b",
                        recv, bif0.c2v_out, bif0.out_frame_id, exp, recv[0]);
            end
            $display("back_to_back: row %0d delivered frame %b", recv, bif0.out_frame_id);
            recv++;
         end
         prev_stall = bif0.out_valid && !out_ready;
         prev_c2v   = bif0.c2v_out;
         prev_f     = bif0.out_frame_id;
         if (sent < 5) begin
            v2c_src  = 1'b0;
            v2c_in   = put_lane(all_lanes(4'b0111), sent, 4'b0001);
            fid      = sent[0];
            in_valid = 1'b1;
            if (bif0.in_ready) sent++;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++; if (recv !== 5) begin n_err++; $display("FAIL bp_count: got %0d expected 5", recv); end
      repeat (3) begin
         #1;
         n_cmp++; if (bif0.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra_row: got %b expected 0", bif0.out_valid); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midstream;
      logic early;
      logic [W-1:0] stim, exp0;
      stim = put_lane(all_lanes(4'b0011), 2, 4'b1001);
      exp0 = put_lane(all_lanes(4'b1001), 2, 4'b0011);
      out_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         v2c_src  = 1'b0;
         v2c_in   = stim;
         fid      = 1'b1;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rstn     = 1'b0;
      #1;
      n_cmp++; if (bif0.in_ready !== 1'b0) begin n_err++; $display("FAIL mrst_in_ready: got %b expected 0", bif0.in_ready); end
      @(negedge clk);
      n_cmp++; if (bif0.out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b expected 0", bif0.out_valid); end
      n_cmp++; if (bif0.c2v_out !== '0) begin n_err++; $display("FAIL mrst_c2v: got %h expected 0", bif0.c2v_out); end
      n_cmp++; if (bif0.out_frame_id !== 1'b0) begin n_err++; $display("FAIL mrst_frame: got %b expected 0", bif0.out_frame_id); end
      rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         n_cmp++; if (bif0.out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_stale: got %b expected 0", bif0.out_valid); end
      end
      issue_row(1'b0, stim, '0, 1'b0, early);
      n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL mrst_new_early: got %b expected 0", early); end
      n_cmp++; if (bif0.out_valid !== 1'b1) begin n_err++; $display("FAIL mrst_new_valid: got %b expected 1", bif0.out_valid); end
      n_cmp++; if (bif0.c2v_out !== exp0) begin n_err++; $display("FAIL mrst_new_c2v: got %h expected %h", bif0.c2v_out, exp0); end
      @(negedge clk);
      $display("test_reset_midstream done");
   endtask

`ifdef ROW_PE_UNSAT_CNT_EN
   task automatic test_unsat_cnt;
      logic [W-1:0] stim1, ch0;
      stim1 = put_lane(all_lanes(4'b0011), 2, 4'b1001);
      ch0   = put_lane(put_lane(all_lanes(4'b0111), 0, 4'b0001), 5, 4'b0001);
      out_ready = 1'b1;
      unsat_clr = 1'b1;
      @(negedge clk);
      unsat_clr = 1'b0;
      n_cmp++; if (unsat_cnt0 !== 16'd0) begin n_err++; $display("FAIL unsat_init: got %0d expected 0", unsat_cnt0); end
      for (int r = 0; r < 5; r++) begin
         v2c_src   = (r >= 3);
         v2c_in    = stim1;
         ch_msg_in = ch0;
         in_valid  = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++; if (unsat_cnt0 !== 16'd3) begin n_err++; $display("FAIL unsat_three: got %0d expected 3", unsat_cnt0); end
      v2c_src  = 1'b0;
      v2c_in   = stim1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bif0.out_valid !== 1'b1 || unsat_cnt0 !== 16'd3) begin
         n_err++; $display("FAIL unsat_pre_clr: got v=%b cnt=%0d expected v=1 cnt=3", bif0.out_valid, unsat_cnt0);
      end
      unsat_clr = 1'b1;
      @(negedge clk);
      unsat_clr = 1'b0;
      n_cmp++; if (unsat_cnt0 !== 16'd0) begin n_err++; $display("FAIL unsat_clr_wins: got %0d expected 0", unsat_cnt0); end
      @(negedge clk);
      n_cmp++; if (unsat_cnt0 !== 16'd0) begin n_err++; $display("FAIL unsat_after_clr: got %0d expected 0", unsat_cnt0); end
      $display("test_unsat_cnt done");
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef ROW_PE_UNSAT_CNT_EN
      unsat_clr = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_basic();
      test_offset();
      test_tie_src();
      test_negzero();
      test_back_to_back();
      test_reset_midstream();
`ifdef ROW_PE_UNSAT_CNT_EN
      test_unsat_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/row_pe_minsum_gen.md
Name: row_pe_minsum_gen

Overview:
- Parametrised next-generation row processing element for the layered IB-LDPC decoder.
- Accepts one row's CN_DEGREE variable-to-check messages in a single beat and returns CN_DEGREE check-to-variable messages.
- Uses offset min-sum with a 3-stage, valid/ready back-pressured pipeline.
- Carries a multi-frame tag alongside each row and emits a per-row parity (syndrome) bit for early termination.

Parameters:
- QUAN_SIZE, 4, message width; sign-magnitude, MSB = sign (1 = negative), low QUAN_SIZE-1 bits = magnitude.
- CN_DEGREE, 10, check-node degree (number of lanes); legal range 2..32.
- OFFSET, 0, magnitude offset subtracted from every output magnitude; legal range 0..2^(QUAN_SIZE-1)-1.
- MULTI_FRAME_NUM, 2, number of interleaved frames; frame tag width is FRAME_BW = max(1, clog2(MULTI_FRAME_NUM)).

Ports:
- read_clk, input, 1, single clock.
- rstn, input, 1, synchronous active-low reset.
- v2c_in, input, CN_DEGREE*QUAN_SIZE, intrinsic v2c messages; lane i at bits [i*QUAN_SIZE +: QUAN_SIZE].
- ch_msg_in, input, CN_DEGREE*QUAN_SIZE, channel messages used in the first iteration.
- v2c_src, input, 1, 1 = take ch_msg_in, 0 = take v2c_in; sampled with in_valid.
- in_frame_id, input, FRAME_BW, frame tag of the input beat.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, input beat accepted when in_valid && in_ready.
- c2v_out, output, CN_DEGREE*QUAN_SIZE, check-to-variable results; same lane packing as v2c_in.
- parity_out, output, 1, XOR of all input signs (1 = check unsatisfied).
- out_frame_id, output, FRAME_BW, tag travelling with the result.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts.
- unsat_cnt, output, 16, unsatisfied-check counter; present only with ROW_PE_UNSAT_CNT_EN.
- unsat_clr, input, 1, counter clear; present only with ROW_PE_UNSAT_CNT_EN.

Behaviour:
- Clocking and reset:
  - All registers update on the rising edge of read_clk.
  - Reset is synchronous; while rstn = 0 every stage-valid bit is cleared on the edge.
  - Reset values: out_valid 0, c2v_out 0, parity_out 0, out_frame_id 0.
  - in_ready is forced 0 while rstn = 0.
  - A reset asserted mid-operation discards all in-flight rows; no partial result is ever emitted.
- Pipeline:
  - Stages: S1 registers the muxed inputs and the tag; S2 computes sign product, min1, min2 and idx1; S3 registers the output lanes and parity.
  - Global enable adv = !out_valid || out_ready; all three stages shift together when adv = 1.
  - in_ready = adv && rstn.
  - Latency: an accepted beat appears on out_valid exactly 3 cycles later if out_ready is held high.
  - Throughput: 1 row per cycle.
  - Bubbles propagate as invalid stages.
  - While out_valid && !out_ready, all outputs hold stable and no stage advances.
- Arithmetic:
  - S2: sgn_all = XOR of the lane sign bits.
  - S2: min1 = smallest magnitude, idx1 = lowest lane index holding min1 (ties go to the lower index).
  - S2: min2 = smallest magnitude over the remaining lanes; min2 == min1 when min1 is duplicated.
  - S3: lane i magnitude m = (i == idx1 ? min2 : min1) minus OFFSET, saturating at 0.
  - S3: lane i sign = sgn_all XOR sign_i.
  - S3: if m == 0 the lane outputs all zeros (no negative zero).
  - Input negative zero (sign 1, magnitude 0) is treated as magnitude 0, but its sign still enters sgn_all.
  - parity_out = sgn_all.
- Frame tag: in_frame_id passes through unchanged; no reordering.

Optional Feature:
- Macro: ROW_PE_UNSAT_CNT_EN.
- Defined:
  - unsat_cnt increments by 1 on every output handshake (out_valid && out_ready) with parity_out = 1.
  - Saturates at 16'hFFFF.
  - unsat_clr = 1 zeroes the counter on the next edge; clear wins over a simultaneous increment.
  - Reset value 0.
- Not defined: unsat_cnt and unsat_clr ports and the counter logic are absent.

Test Plan (QUAN_SIZE=4, CN_DEGREE=10):
- Basic min-sum, OFFSET=0, v2c_src=0, out_ready=1:
  - Stimulus: all lanes 4'b0011, lane 2 = 4'b1001.
  - Response, 3 cycles later: lane 2 = 4'b0011, all other lanes = 4'b1001, parity_out=1.
- Offset and zero forcing, OFFSET=1, same stimulus:
  - Response: lane 2 = 4'b0010, all other lanes = 4'b0000, parity_out=1.
- Tie and source select:
  - Stimulus: v2c_src=1, ch_msg_in lanes 0 and 5 = 4'b0001, all others 4'b0111, OFFSET=0.
  - Response: every lane magnitude 1, all signs 0, parity_out=0; v2c_in ignored.
- Back-pressure:
  - Stimulus: stream 5 rows with frame ids alternating 0/1; hold out_ready=0 for 4 cycles after the first out_valid.
  - Response: in_ready drops in the same cycle; out_valid, c2v_out and out_frame_id stay stable; all 5 rows delivered in order, none lost or duplicated.
- Reset mid-stream:
  - Stimulus: drop rstn for 1 cycle with 3 rows in flight.
  - Response: out_valid=0 and c2v_out=0 after the edge; no stale row emerges; a new row issued afterwards appears 3 cycles later.
- ROW_PE_UNSAT_CNT_EN:
  - Stimulus: 3 rows with parity 1, 2 rows with parity 0, then unsat_clr pulsed together with another parity-1 handshake.
  - Response: unsat_cnt = 3 before the clear, 0 after it.
